// File: rtl/datapath_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : datapath_sequencer_if
// Purpose  : Instruction valid/ready handshake between source and sequencer.
// Revision : 1.0
// ============================================================================
interface datapath_sequencer_if;
    logic [7:0] i_instr;
    logic       i_instrValid;
    logic       o_instrReady;

    modport master (output i_instr, output i_instrValid, input o_instrReady);
    modport slave  (input i_instr, input i_instrValid, output o_instrReady);
endinterface
`default_nettype wire

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : datapath_sequencer
// Purpose  : Multi-cycle control sequencer for the 8-bit bus datapath.
// Revision : 1.0
// ============================================================================
module datapath_sequencer #(
    parameter int RAM_WAIT = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    datapath_sequencer_if.slave  if_instr,
    output logic                 o_done,
    output logic                 o_halted,
    input  logic                 i_aluFlagN,
    input  logic                 i_aluFlagZ,
    output logic                 o_flagN,
    output logic                 o_flagZ,
    output logic                 o_ctrlAluOE,
    output logic                 o_ctrlAluSub,
    output logic                 o_ctrlAluShiftLeft,
    output logic                 o_ctrlAluBWr,
    output logic [1:0]           o_ctrlAluOp,
    output logic                 o_ctrlRegWr0,
    output logic                 o_ctrlRegWr1,
    output logic                 o_ctrlRegBusSel,
    output logic                 o_ctrlRegBusEn,
    output logic                 o_ctrlAluSel,
    output logic                 o_ctrlRamAddressEn,
    output logic                 o_ctrlRamWriteEn,
    output logic                 o_ctrlRamReadDataSelect,
    output logic                 o_ctrlRamOE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EX1  = 3'd1,
        S_WAIT = 3'd2,
        S_EX2  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    typedef struct packed {
        logic       aluOE;
        logic       aluSub;
        logic       aluShl;
        logic       aluBWr;
        logic [1:0] aluOp;
        logic       regWr0;
        logic       regWr1;
        logic       regBusSel;
        logic       regBusEn;
        logic       aluSel;
        logic       ramAddrEn;
        logic       ramWrEn;
        logic       ramOE;
        logic       done;
    } ctrl_t;

    localparam logic [2:0] c_RAM_WAIT  = 3'(RAM_WAIT);
    localparam logic [1:0] c_CLS_ALU   = 2'b00;
    localparam logic [1:0] c_CLS_LOAD  = 2'b01;
    localparam logic [1:0] c_CLS_STORE = 2'b10;

    state_t     r_state, w_nextState;
    logic [7:0] r_instr, w_instr;
    logic [2:0] r_waitCnt, w_waitCnt;
    ctrl_t      r_ctrl, w_ctrl;
    logic       r_halted, r_flagN, r_flagZ;
    logic       w_ready, w_accept, w_src, w_dst;

    assign w_ready               = (r_state == S_IDLE) & ~r_halted;
    assign w_accept              = if_instr.i_instrValid & w_ready;
    assign if_instr.o_instrReady = w_ready;

    always_comb begin
        w_nextState = r_state;
        w_instr     = r_instr;
        w_waitCnt   = r_waitCnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = S_EX1;
                    w_instr     = if_instr.i_instr;
                end
            end
            S_EX1: begin
                if (r_instr[7:6] == 2'b11) begin
                    w_nextState = r_instr[5] ? S_HALT : S_IDLE;
                end else if ((r_instr[7:6] != c_CLS_ALU) && (c_RAM_WAIT != 3'd0)) begin
                    w_nextState = S_WAIT;
                    w_waitCnt   = c_RAM_WAIT;
                end else begin
                    w_nextState = S_EX2;
                end
            end
            S_WAIT: begin
                w_waitCnt = r_waitCnt - 3'd1;
                if (r_waitCnt <= 3'd1) begin
                    w_nextState = S_EX2;
                end
            end
            S_EX2:   w_nextState = S_IDLE;
            S_HALT:  w_nextState = S_HALT;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Controls are decoded for the state being entered so they register into place on time.
    assign w_src = w_instr[0];
    assign w_dst = w_instr[1];

    always_comb begin
        w_ctrl = '0;
        case (w_nextState)
            S_EX1: begin
                case (w_instr[7:6])
                    c_CLS_ALU: begin
                        w_ctrl.regBusSel = w_src;
                        w_ctrl.regBusEn  = 1'b1;
                        w_ctrl.aluBWr    = 1'b1;
                    end
                    c_CLS_LOAD, c_CLS_STORE: begin
                        w_ctrl.regBusSel = (w_instr[7:6] == c_CLS_STORE) ? w_dst : w_src;
                        w_ctrl.regBusEn  = 1'b1;
                        w_ctrl.ramAddrEn = 1'b1;
                    end
                    default: begin
                        w_ctrl.done = 1'b1;
                        if (!w_instr[5]) begin
                            w_ctrl.regBusSel = w_src;
                            w_ctrl.regBusEn  = 1'b1;
                            w_ctrl.regWr0    = ~w_dst;
                            w_ctrl.regWr1    = w_dst;
                        end
                    end
                endcase
            end
            S_EX2: begin
                w_ctrl.done = 1'b1;
                case (w_instr[7:6])
                    c_CLS_ALU: begin
                        w_ctrl.aluSel = w_dst;
                        w_ctrl.aluOE  = 1'b1;
                        w_ctrl.aluOp  = w_instr[5:4];
                        w_ctrl.aluSub = w_instr[3];
                        w_ctrl.aluShl = w_instr[2];
                        w_ctrl.regWr0 = ~w_dst;
                        w_ctrl.regWr1 = w_dst;
                    end
                    c_CLS_LOAD: begin
                        w_ctrl.ramOE  = 1'b1;
                        w_ctrl.regWr0 = ~w_dst;
                        w_ctrl.regWr1 = w_dst;
                    end
                    c_CLS_STORE: begin
                        w_ctrl.regBusSel = w_src;
                        w_ctrl.regBusEn  = 1'b1;
                        w_ctrl.ramWrEn   = 1'b1;
                    end
                    default: w_ctrl.done = 1'b1;
                endcase
            end
            default: w_ctrl = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_instr   <= 8'h00;
            r_waitCnt <= 3'd0;
            r_ctrl    <= '0;
            r_halted  <= 1'b0;
            r_flagN   <= 1'b0;
            r_flagZ   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_instr   <= w_instr;
            r_waitCnt <= w_waitCnt;
            r_ctrl    <= w_ctrl;
            r_halted  <= (w_nextState == S_HALT);
            if ((r_state == S_EX2) && (r_instr[7:6] == c_CLS_ALU)) begin
                r_flagN <= i_aluFlagN;
                r_flagZ <= i_aluFlagZ;
            end
        end
    end

    assign o_done                  = r_ctrl.done;
    assign o_halted                = r_halted;
    assign o_flagN                 = r_flagN;
    assign o_flagZ                 = r_flagZ;
    assign o_ctrlAluOE             = r_ctrl.aluOE;
    assign o_ctrlAluSub            = r_ctrl.aluSub;
    assign o_ctrlAluShiftLeft      = r_ctrl.aluShl;
    assign o_ctrlAluBWr            = r_ctrl.aluBWr;
    assign o_ctrlAluOp             = r_ctrl.aluOp;
    assign o_ctrlRegWr0            = r_ctrl.regWr0;
    assign o_ctrlRegWr1            = r_ctrl.regWr1;
    assign o_ctrlRegBusSel         = r_ctrl.regBusSel;
    assign o_ctrlRegBusEn          = r_ctrl.regBusEn;
    assign o_ctrlAluSel            = r_ctrl.aluSel;
    assign o_ctrlRamAddressEn      = r_ctrl.ramAddrEn;
    assign o_ctrlRamWriteEn        = r_ctrl.ramWrEn;
    assign o_ctrlRamReadDataSelect = 1'b0;
    assign o_ctrlRamOE             = r_ctrl.ramOE;

endmodule
`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_sequencer
// Purpose  : Bench with a bus-level datapath model and an instruction-level scoreboard.
// Revision : 1.0
// ============================================================================
module tb_datapath_sequencer;
    localparam int RW = 2;

    typedef struct packed {
        logic       aluOE;
        logic       aluSub;
        logic       aluShl;
        logic       aluBWr;
        logic [1:0] aluOp;
        logic       regWr0;
        logic       regWr1;
        logic       regBusSel;
        logic       regBusEn;
        logic       aluSel;
        logic       ramAddrEn;
        logic       ramWrEn;
        logic       ramRdSel;
        logic       ramOE;
        logic       done;
    } ctrl_t;

    typedef struct packed {
        ctrl_t      c;
        logic       last;
        logic [7:0] instr;
    } exp_t;

    typedef struct {
        logic [7:0] ins, r0, r1, er0, er1;
        logic       en, ez;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_sequencer_if bus ();

    logic       done, halted, flagN, flagZ, aluFlagN, aluFlagZ;
    logic       aluOE, aluSub, aluShl, aluBWr, regWr0, regWr1, regBusSel, regBusEn;
    logic       aluSel, ramAddrEn, ramWrEn, ramRdSel, ramOE;
    logic [1:0] aluOp;
    ctrl_t      act;

    datapath_sequencer #(.RAM_WAIT(RW)) dut (
        .i_clk                   (clk),
        .i_reset                 (rst),
        .if_instr                (bus),
        .o_done                  (done),
        .o_halted                (halted),
        .i_aluFlagN              (aluFlagN),
        .i_aluFlagZ              (aluFlagZ),
        .o_flagN                 (flagN),
        .o_flagZ                 (flagZ),
        .o_ctrlAluOE             (aluOE),
        .o_ctrlAluSub            (aluSub),
        .o_ctrlAluShiftLeft      (aluShl),
        .o_ctrlAluBWr            (aluBWr),
        .o_ctrlAluOp             (aluOp),
        .o_ctrlRegWr0            (regWr0),
        .o_ctrlRegWr1            (regWr1),
        .o_ctrlRegBusSel         (regBusSel),
        .o_ctrlRegBusEn          (regBusEn),
        .o_ctrlAluSel            (aluSel),
        .o_ctrlRamAddressEn      (ramAddrEn),
        .o_ctrlRamWriteEn        (ramWrEn),
        .o_ctrlRamReadDataSelect (ramRdSel),
        .o_ctrlRamOE             (ramOE)
    );

    assign act = {aluOE, aluSub, aluShl, aluBWr, aluOp, regWr0, regWr1, regBusSel,
                  regBusEn, aluSel, ramAddrEn, ramWrEn, ramRdSel, ramOE, done};

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op, input logic sub, input logic shl);
        logic [7:0] r;
        case (op)
            2'd0:    r = sub ? (a - b) : (a + b);
            2'd1:    r = a & b;
            2'd2:    r = a | b;
            default: r = a ^ b;
        endcase
        if (shl) r = r << 1;
        return r;
    endfunction

    // Datapath model: registers, ALU B latch and RAM, driven purely by the DUT strobes.
    logic [7:0] dp_r [2];
    logic [7:0] dp_ram [256];
    logic [7:0] dp_b = 8'h00, dp_addr = 8'h00;
    logic [7:0] live, dbus;
    logic       pre_en = 1'b0, init_ram = 1'b0;
    logic [7:0] pre_r0 = 8'h00, pre_r1 = 8'h00;

    assign live     = alu(dp_r[aluSel], dp_b, aluOp, aluSub, aluShl);
    assign aluFlagN = live[7];
    assign aluFlagZ = (live == 8'h00);

    always_comb begin
        dbus = 8'h00;
        if (regBusEn)   dbus = dp_r[regBusSel];
        else if (aluOE) dbus = live;
        else if (ramOE) dbus = dp_ram[dp_addr];
    end

    always @(posedge clk) begin
        if (init_ram) for (int i = 0; i < 256; i++) dp_ram[i] <= 8'(i) ^ 8'h5A;
        if (pre_en) begin
            dp_r[0] <= pre_r0;
            dp_r[1] <= pre_r1;
        end else begin
            if (regWr0) dp_r[0] <= dbus;
            if (regWr1) dp_r[1] <= dbus;
        end
        if (aluBWr)    dp_b    <= dbus;
        if (ramAddrEn) dp_addr <= dbus;
        if (ramWrEn)   dp_ram[dp_addr] <= dbus;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, expv, $time);
        end
    endtask

    // Instruction-level reference: architectural state plus per-cycle expected strobes.
    exp_t       q[$];
    logic [7:0] ar [2];
    logic [7:0] aram [256];
    logic       m_n = 1'b0, m_z = 1'b0, m_halt = 1'b0;

    task automatic push_seq(input logic [7:0] ins);
        exp_t  e;
        ctrl_t c;
        logic  s, d;
        s = ins[0];
        d = ins[1];
        e.instr = ins;
        e.last  = 1'b0;
        c = '0;
        case (ins[7:6])
            2'b00: begin
                c.regBusSel = s; c.regBusEn = 1'b1; c.aluBWr = 1'b1;
                e.c = c; q.push_back(e);
                c = '0;
                c.aluSel = d; c.aluOE = 1'b1; c.aluOp = ins[5:4];
                c.aluSub = ins[3]; c.aluShl = ins[2];
                c.regWr0 = ~d; c.regWr1 = d; c.done = 1'b1;
                e.c = c; e.last = 1'b1; q.push_back(e);
            end
            2'b01, 2'b10: begin
                c.regBusSel = ins[7] ? d : s; c.regBusEn = 1'b1; c.ramAddrEn = 1'b1;
                e.c = c; q.push_back(e);
                e.c = '0;
                for (int k = 0; k < RW; k++) q.push_back(e);
                c = '0;
                c.done = 1'b1;
                if (ins[7]) begin
                    c.regBusSel = s; c.regBusEn = 1'b1; c.ramWrEn = 1'b1;
                end else begin
                    c.ramOE = 1'b1; c.regWr0 = ~d; c.regWr1 = d;
                end
                e.c = c; e.last = 1'b1; q.push_back(e);
            end
            default: begin
                c.done = 1'b1;
                if (!ins[5]) begin
                    c.regBusSel = s; c.regBusEn = 1'b1; c.regWr0 = ~d; c.regWr1 = d;
                end
                e.c = c; e.last = 1'b1; q.push_back(e);
            end
        endcase
    endtask

    task automatic exec(input logic [7:0] ins);
        logic       s, d;
        logic [7:0] r;
        s = ins[0];
        d = ins[1];
        case (ins[7:6])
            2'b00: begin
                r = alu(ar[d], ar[s], ins[5:4], ins[3], ins[2]);
                ar[d] = r;
                m_n = r[7];
                m_z = (r == 8'h00);
            end
            2'b01: ar[d] = aram[ar[s]];
            2'b10: aram[ar[d]] = ar[s];
            default: if (ins[5]) m_halt = 1'b1; else ar[d] = ar[s];
        endcase
    endtask

    initial begin
        exp_t  e;
        ctrl_t ec;
        logic  have, rdy;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                m_n = 1'b0; m_z = 1'b0; m_halt = 1'b0;
            end
            if (init_ram) for (int i = 0; i < 256; i++) aram[i] = 8'(i) ^ 8'h5A;
            have = (q.size() != 0);
            ec = '0;
            e = '0;
            if (have) begin
                e = q.pop_front();
                ec = e.c;
            end
            rdy = !have && !m_halt;
            chk("ctrl", act, ec);
            chk("ready", bus.o_instrReady, rdy);
            chk("halted", halted, m_halt);
            chk("flags", {flagN, flagZ}, {m_n, m_z});
            chk("bus_excl", ($countones({regBusEn, aluOE, ramOE}) <= 1), 1);
            chk("wr_excl", !(regWr0 && regWr1), 1);
            if (!have && !rst) chk("regs", {dp_r[0], dp_r[1]}, {ar[0], ar[1]});
            if (have && e.last) exec(e.instr);
            if (!rst && bus.i_instrValid && rdy) push_seq(bus.i_instr);
            if (pre_en) begin
                ar[0] = pre_r0;
                ar[1] = pre_r1;
            end
        end
    end

    task automatic preset(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk); #1;
        pre_r0 = a; pre_r1 = b; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic seen;
        preset(v.r0, v.r1);
        bus.i_instr = v.ins;
        bus.i_instrValid = 1'b1;
        @(posedge clk); #1;
        bus.i_instrValid = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = done;
        end
        if (!seen) chk("done_timeout", 0, 1);
        else       chk("latency", n, v.lat);
        @(negedge clk);
        chk("vec_r0", dp_r[0], v.er0);
        chk("vec_r1", dp_r[1], v.er1);
        chk("vec_flags", {flagN, flagZ}, {v.en, v.ez});
    endtask

    vec_t tbl [10];

    initial begin
        logic [7:0] ins;
        int nd, nr;
        tbl[0] = '{8'h0D, 8'h05, 8'h05, 8'h00, 8'h05, 1'b0, 1'b1, 2};
        tbl[1] = '{8'h01, 8'h03, 8'h04, 8'h07, 8'h04, 1'b0, 1'b0, 2};
        tbl[2] = '{8'h13, 8'h10, 8'hF0, 8'h10, 8'hF0, 1'b1, 1'b0, 2};
        tbl[3] = '{8'h36, 8'h41, 8'h03, 8'h41, 8'h84, 1'b1, 1'b0, 2};
        tbl[4] = '{8'h08, 8'h77, 8'h12, 8'h00, 8'h12, 1'b0, 1'b1, 2};
        tbl[5] = '{8'hC1, 8'h01, 8'h09, 8'h09, 8'h09, 1'b0, 1'b1, 1};
        tbl[6] = '{8'hC2, 8'hAA, 8'h00, 8'hAA, 8'hAA, 1'b0, 1'b1, 1};
        tbl[7] = '{8'h42, 8'h10, 8'h33, 8'h10, 8'h4A, 1'b0, 1'b1, 4};
        tbl[8] = '{8'h81, 8'h20, 8'h99, 8'h20, 8'h99, 1'b0, 1'b1, 4};
        tbl[9] = '{8'h40, 8'h20, 8'h00, 8'h99, 8'h00, 1'b0, 1'b1, 4};

        bus.i_instr = 8'h00;
        bus.i_instrValid = 1'b0;
        init_ram = 1'b1;
        pre_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        init_ram = 1'b0;
        pre_en = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", act, 0);
        chk("rst_ready", bus.o_instrReady, 1);
        chk("rst_halted", halted, 0);
        chk("rst_flags", {flagN, flagZ}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // MOV held valid: one issue every second cycle.
        preset(8'h01, 8'h5C);
        bus.i_instr = 8'hC1;
        bus.i_instrValid = 1'b1;
        nd = 0;
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nd += int'(done);
            nr += int'(bus.o_instrReady);
        end
        @(posedge clk); #1;
        bus.i_instrValid = 1'b0;
        chk("mov_done_count", nd, 4);
        chk("mov_ready_count", nr, 4);
        @(negedge clk);
        chk("mov_r0", dp_r[0], 8'h5C);

        // Reset during EX1 of an ALU instruction aborts it.
        preset(8'h03, 8'h04);
        bus.i_instr = 8'h01;
        bus.i_instrValid = 1'b1;
        @(posedge clk); #1;
        bus.i_instrValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bwr", aluBWr, 0);
        chk("abort_ctrl", act, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_wr", {regWr0, regWr1}, 0);
        end
        chk("abort_r0", dp_r[0], 8'h03);

        // Randomized traffic, HALT excluded.
        preset(8'($urandom), 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            ins = 8'($urandom);
            if (ins[7:6] == 2'b11) ins[5] = 1'b0;
            bus.i_instr = ins;
            bus.i_instrValid = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        bus.i_instrValid = 1'b0;
        repeat (8) @(negedge clk);

        // HALT, then ignored traffic, then reset recovery.
        @(posedge clk); #1;
        bus.i_instr = 8'hE0;
        bus.i_instrValid = 1'b1;
        @(posedge clk); #1;
        bus.i_instr = 8'h01;
        @(negedge clk);
        chk("halt_done", done, 1);
        @(negedge clk);
        chk("halt_halted", halted, 1);
        chk("halt_ready", bus.o_instrReady, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_quiet", act, 0);
        end
        @(posedge clk); #1;
        bus.i_instrValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_ready", bus.o_instrReady, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit bus datapath (ALU, two-register regset, RAM with address latch).
- Accepts one 8-bit instruction per valid/ready handshake and drives the datapath control strobes cycle by cycle.
- Guarantees exactly one bus driver per bus-using cycle, captures ALU flags, and signals completion.
- Sits between the instruction source (fetch unit or test bench) and the datapath control inputs.

Parameters:
- RAM_WAIT, 0, extra wait cycles (0..7) inserted between the RAM address-latch cycle and the RAM data cycle for LOAD/STORE.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_instr  input  8  instruction; sampled on handshake.
- i_instrValid  input  1  instruction present.
- o_instrReady  output  1  sequencer can accept an instruction (high only in IDLE).
- o_done  output  1  one-cycle pulse in the last execute cycle of each instruction.
- o_halted  output  1  HALT executed; stays high until reset.
- i_aluFlagN, i_aluFlagZ  input  1 each  live ALU flags from the datapath.
- o_flagN, o_flagZ  output  1 each  flags latched from the last ALU instruction.
- o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlAluBWr  output  1 each  ALU controls.
- o_ctrlAluOp  output  2  ALU operation select.
- o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel  output  1 each  regset controls.
- o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE  output  1 each  RAM controls.

Behaviour:
- Reset: asynchronous. State goes to IDLE. All o_ctrl* = 0, o_done = 0, o_halted = 0, o_flagN = o_flagZ = 0, wait counter = 0. A reset mid-instruction aborts it immediately; no partial write completes after reset asserts.
- Control outputs are registered (Moore, decoded from state plus the latched instruction). o_ctrlRamReadDataSelect is always 0.
- Encoding, i_instr[7:0]:
  - [7:6] class: 00 ALU, 01 LOAD, 10 STORE, 11 MISC.
  - [5:4] aluOp; [3] sub; [2] shiftLeft.
  - [1] dst register; [0] src register.
  - MISC: [5] 0 = MOV, 1 = HALT.
- Handshake: transfer occurs when i_instrValid & o_instrReady at a rising edge. The instruction is latched and the state moves to EX1. o_instrReady = (state == IDLE) & ~o_halted.
- States: IDLE, EX1, WAIT, EX2, HALT.
- ALU:
  - EX1: RegBusSel = src, RegBusEn = 1, AluBWr = 1 (B <= reg[src]).
  - EX2: AluSel = dst, AluOE = 1, AluOp/Sub/ShiftLeft from the instruction, RegWr[dst] = 1.
  - At the end of EX2: o_flagN <= i_aluFlagN, o_flagZ <= i_aluFlagZ.
  - Latency: 2 cycles.
- LOAD (dst <= RAM[reg[src]]):
  - EX1: RegBusSel = src, RegBusEn = 1, RamAddressEn = 1.
  - WAIT: RAM_WAIT cycles, all controls 0.
  - EX2: RamOE = 1, RegWr[dst] = 1.
- STORE (RAM[reg[dst]] <= reg[src]):
  - EX1: RegBusSel = dst, RegBusEn = 1, RamAddressEn = 1.
  - WAIT: as for LOAD.
  - EX2: RegBusSel = src, RegBusEn = 1, RamWriteEn = 1.
- WAIT is entered only if RAM_WAIT > 0. The counter counts RAM_WAIT..1 and EX2 follows when it reaches 1. LOAD/STORE latency = 2 + RAM_WAIT.
- MOV: EX1 only. RegBusSel = src, RegBusEn = 1, RegWr[dst] = 1. Returns to IDLE. Latency 1. dst == src is legal (no-op write).
- HALT: EX1 drives no controls, pulses o_done, then enters HALT. o_halted = 1 and o_instrReady = 0 until reset.
- o_done is asserted during the final execute cycle (EX2, or EX1 for MOV/HALT). The next state is IDLE, so back-to-back instructions have one IDLE cycle between them. Minimum issue interval = latency + 1.
- Bus exclusivity: per cycle, at most one of {RegBusEn, AluOE, RamOE} is set. RegWr0 and RegWr1 are never both set.
- Flags are unaffected by non-ALU instructions.
- i_instr and i_instrValid are ignored outside IDLE.

Test Plan:
- Reset → all outputs 0, o_instrReady = 1. Assert reset during EX1 of an ALU instruction → outputs 0 in the same cycle, no RegWr pulse follows.
- ALU 0x0D (add, sub = 1, dst = 0, src = 1) with r0 = 5, r1 = 5 → EX1 AluBWr & RegBusSel = 1; EX2 AluOE, RegWr0, AluSub; o_flagZ = 1, o_flagN = 0; o_done in cycle 2.
- LOAD 0x42 with RAM_WAIT = 2 → RamAddressEn at cycle 1, two idle cycles, RamOE & RegWr1 at cycle 4 together with o_done.
- STORE 0x81, then LOAD back into the other register → the read value equals the stored value. Flags remain at their previous values.
- MOV 0xC1 held valid continuously → o_done every 2nd cycle, o_instrReady toggles 1/0, r0 = r1.
- HALT 0xE0 → o_done pulse, then o_halted = 1 and o_instrReady = 0. Later valid instructions produce no controls; reset clears o_halted.
- Assertion throughout all tests: bus-driver exclusivity and no double register write.
